// File: rtl/conv_post_process.sv
// conv_post_process: bias add, rounding requantization, saturation and
// optional ReLU for one output pixel's accumulator vector, plus row/frame
// position tagging for the feature-map writer.
// Optional feature: define CONV_POST_RELU_EN to clamp negative results to 0.
// Pipeline: stage 1 bias add, stage 2 round+shift, stage 3 saturate/ReLU
// and line_end/frame_end tagging (3-cycle latency, one beat per cycle).
module conv_post_process #(
  parameter int CONV_OUT_NUM     = 18,
  parameter int DATA_WIDTH       = 8,
  parameter int ACC_WIDTH        = 24,
  parameter int BIAS_WIDTH       = 16,
  parameter int SHIFT_WIDTH      = 5,
  parameter int ROW_BUFFER_DEPTH = 9
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [CONV_OUT_NUM*ACC_WIDTH-1:0]    acc_in,
  input  logic                                 valid_in,
  input  logic [CONV_OUT_NUM*BIAS_WIDTH-1:0]   bias_in,
  input  logic [SHIFT_WIDTH-1:0]               shift_ctrl,
  input  logic [ROW_BUFFER_DEPTH-1:0]          line_len_ctrl,
  input  logic [ROW_BUFFER_DEPTH-1:0]          frame_rows_ctrl,
  input  logic                                 cfg_rst,
  output logic [CONV_OUT_NUM*DATA_WIDTH-1:0]   data_out,
  output logic                                 valid_out,
  output logic                                 line_end,
  output logic                                 frame_end
);

  localparam int S1W = ACC_WIDTH + 1;
  localparam int S2W = ACC_WIDTH + 2;
  localparam logic signed [S2W-1:0] SAT_MAX = (S2W'(1) <<< (DATA_WIDTH - 1)) - S2W'(1);
  localparam logic signed [S2W-1:0] SAT_MIN = -SAT_MAX - S2W'(1);

  logic                        r_v1;
  logic                        r_v2;
  logic [ROW_BUFFER_DEPTH-1:0] r_col;
  logic [ROW_BUFFER_DEPTH-1:0] r_row;
  logic [ROW_BUFFER_DEPTH-1:0] w_col_last;
  logic [ROW_BUFFER_DEPTH-1:0] w_row_last;
  logic                        w_is_line_end;
  logic                        w_is_frame_end;
  logic                        w_ld1;
  logic                        w_ld2;
  logic                        w_ld3;

  // A zero length/row count behaves as one, so every beat closes a row/frame.
  assign w_col_last = (line_len_ctrl == '0) ? '0 : line_len_ctrl - ROW_BUFFER_DEPTH'(1);
  assign w_row_last = (frame_rows_ctrl == '0) ? '0 : frame_rows_ctrl - ROW_BUFFER_DEPTH'(1);

  // ">=" rather than "==" so a mid-frame shrink of the controls still wraps.
  assign w_is_line_end  = (r_col >= w_col_last);
  assign w_is_frame_end = w_is_line_end && (r_row >= w_row_last);

  // Data registers load only for live beats; cfg_rst leaves them alone.
  assign w_ld1 = valid_in && !cfg_rst;
  assign w_ld2 = r_v1 && !cfg_rst;
  assign w_ld3 = r_v2 && !cfg_rst;

  // Valid pipeline; cfg_rst flushes in-flight beats and drops this cycle's input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      valid_out <= 1'b0;
    end else if (cfg_rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      r_v1      <= valid_in;
      r_v2      <= r_v1;
      valid_out <= r_v2;
    end
  end

  // Position counters advance as a beat enters stage 3; tags register with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col     <= '0;
      r_row     <= '0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else if (cfg_rst) begin
      r_col     <= '0;
      r_row     <= '0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      line_end  <= r_v2 && w_is_line_end;
      frame_end <= r_v2 && w_is_frame_end;
      if (r_v2) begin
        if (w_is_line_end) begin
          r_col <= '0;
          r_row <= w_is_frame_end ? '0 : r_row + ROW_BUFFER_DEPTH'(1);
        end else begin
          r_col <= r_col + ROW_BUFFER_DEPTH'(1);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CONV_OUT_NUM; gi++) begin : g_ch
      logic signed [ACC_WIDTH-1:0]  w_acc;
      logic signed [BIAS_WIDTH-1:0] w_bias;
      logic signed [S2W-1:0]        w_rnd;
      logic signed [S2W-1:0]        w_sum;
      logic signed [S2W-1:0]        w_s2;
      logic signed [DATA_WIDTH-1:0] w_sat;
      logic signed [DATA_WIDTH-1:0] w_act;
      logic signed [S1W-1:0]        r_s1;
      logic signed [S2W-1:0]        r_s2;
      logic [DATA_WIDTH-1:0]        r_q;

      assign w_acc  = acc_in[gi*ACC_WIDTH +: ACC_WIDTH];
      assign w_bias = bias_in[gi*BIAS_WIDTH +: BIAS_WIDTH];

      // Half-LSB rounding constant; zero when no shift is requested.
      assign w_rnd = (shift_ctrl == '0) ? '0
                   : ({{(S2W-1){1'b0}}, 1'b1} << (shift_ctrl - SHIFT_WIDTH'(1)));
      assign w_sum = S2W'(r_s1) + w_rnd;
      assign w_s2  = w_sum >>> shift_ctrl;

      // Clamp to the signed output range, then optionally rectify.
      always_comb begin
        w_sat = r_s2[DATA_WIDTH-1:0];
        if (r_s2 > SAT_MAX) begin
          w_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (r_s2 < SAT_MIN) begin
          w_sat = SAT_MIN[DATA_WIDTH-1:0];
        end
`ifdef CONV_POST_RELU_EN
        w_act = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
        w_act = w_sat;
`endif
      end

      // Three data stages: bias add, round+shift, saturated result.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_s1 <= '0;
          r_s2 <= '0;
          r_q  <= '0;
        end else begin
          if (w_ld1) r_s1 <= S1W'(w_acc) + S1W'(w_bias);
          if (w_ld2) r_s2 <= w_s2;
          if (w_ld3) r_q  <= w_act;
        end
      end

      assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_q;
    end
  endgenerate

endmodule

// File: tb/tb_conv_post_process.sv
// Self-checking bench for conv_post_process: randomized beats checked against
// an integer-arithmetic model of bias/round/saturate/ReLU and a beat-count
// model of row/frame tagging. Build with CONV_POST_RELU_EN to test ReLU.
module tb_conv_post_process;

  localparam int N  = 18;
  localparam int DW = 8;
  localparam int AW = 24;
  localparam int BW = 16;
  localparam int SW = 5;
  localparam int RW = 9;
  localparam int DV = N*DW;

  typedef struct {
    logic [DV-1:0] d;
    logic          le;
    logic          fe;
  } beat_t;

  logic            clk;
  logic            rstn;
  logic [N*AW-1:0] acc_in;
  logic            valid_in;
  logic [N*BW-1:0] bias_in;
  logic [SW-1:0]   shift_ctrl;
  logic [RW-1:0]   line_len_ctrl;
  logic [RW-1:0]   frame_rows_ctrl;
  logic            cfg_rst;
  logic [DV-1:0]   data_out;
  logic            valid_out;
  logic            line_end;
  logic            frame_end;

  int    checks = 0;
  int    passes = 0;
  int    beat_n = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];

  conv_post_process dut (
    .clk             (clk),
    .rstn            (rstn),
    .acc_in          (acc_in),
    .valid_in        (valid_in),
    .bias_in         (bias_in),
    .shift_ctrl      (shift_ctrl),
    .line_len_ctrl   (line_len_ctrl),
    .frame_rows_ctrl (frame_rows_ctrl),
    .cfg_rst         (cfg_rst),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .line_end        (line_end),
    .frame_end       (frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output beat away from the active edge.
  always @(negedge clk) begin
    beat_t b;
    if (rstn === 1'b1 && valid_out === 1'b1) begin
      b.d  = data_out;
      b.le = line_end;
      b.fe = frame_end;
      obs_q.push_back(b);
    end
  end

  // Reference: exact integer arithmetic with floor division for the shift.
  function automatic logic [DV-1:0] model_pix(input logic [N*AW-1:0] acc,
                                              input logic [N*BW-1:0] bias,
                                              input int sh);
    logic [DV-1:0] r;
    longint s1, s2, d, n;
    r = '0;
    for (int k = 0; k < N; k++) begin
      s1 = longint'($signed(acc[k*AW +: AW])) + longint'($signed(bias[k*BW +: BW]));
      if (sh == 0) begin
        s2 = s1;
      end else begin
        d  = longint'(1) << sh;
        n  = s1 + d/2;
        s2 = n / d;
        if ((n % d) != 0 && n < 0) s2 = s2 - 1;
      end
      if (s2 > 127)  s2 = 127;
      if (s2 < -128) s2 = -128;
`ifdef CONV_POST_RELU_EN
      if (s2 < 0) s2 = 0;
`endif
      r[k*DW +: DW] = s2[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_acc();
    int v;
    v = $urandom;
    v = v >>> $urandom_range(8, 28);
    return v[AW-1:0];
  endfunction

  function automatic logic [N*AW-1:0] rand_acc_vec();
    logic [N*AW-1:0] a;
    for (int k = 0; k < N; k++) a[k*AW +: AW] = rand_acc();
    return a;
  endfunction

  function automatic logic [N*BW-1:0] rand_bias_vec();
    logic [N*BW-1:0] b;
    int v;
    for (int k = 0; k < N; k++) begin
      v = $urandom;
      v = v >>> $urandom_range(18, 28);
      b[k*BW +: BW] = v[BW-1:0];
    end
    return b;
  endfunction

  // Drive one valid beat and queue its expected output and position tags.
  task automatic send(input logic [N*AW-1:0] a);
    beat_t e;
    int L, R;
    L = (line_len_ctrl == 0) ? 1 : int'(line_len_ctrl);
    R = (frame_rows_ctrl == 0) ? 1 : int'(frame_rows_ctrl);
    e.d  = model_pix(a, bias_in, int'(shift_ctrl));
    e.le = ((beat_n % L) == L - 1);
    e.fe = e.le && (((beat_n / L) % R) == R - 1);
    beat_n = (beat_n + 1) % (L * R);
    exp_q.push_back(e);
    acc_in   = a;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    cfg_rst = 1'b1;
    @(posedge clk); #1;
    cfg_rst = 1'b0;
    beat_n = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    beat_t e;
    checks++;
    if (valid_out !== 1'b0 || line_end !== 1'b0 || frame_end !== 1'b0 || data_out !== '0)
      $display("FAIL reset_init: vo=%b le=%b fe=%b data=%h, required all 0",
               valid_out, line_end, frame_end, data_out);
    else passes++;
    rstn = 1'b1;
    idle(1);
    // Mid-stream reset: the first beat is on valid_out when rstn drops.
    send(rand_acc_vec());
    send(rand_acc_vec());
    send(rand_acc_vec());
    checks++;
    if (valid_out !== 1'b1) $display("FAIL reset_prefill: valid_out=%b, required 1", valid_out);
    else passes++;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || line_end !== 1'b0 || frame_end !== 1'b0 || data_out !== '0)
      $display("FAIL reset_async: vo=%b le=%b fe=%b data=%h, required all 0",
               valid_out, line_end, frame_end, data_out);
    else passes++;
    @(posedge clk); #1;
    rstn = 1'b1;
    beat_n = 0;
    exp_q.delete();
    obs_q.delete();
    // First beat after release must appear exactly 3 cycles later.
    send(rand_acc_vec());
    e = exp_q[0];
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (valid_out !== (c == 3))
        $display("FAIL reset_latency: cycle %0d valid_out=%b, required %b", c, valid_out, c == 3);
      else passes++;
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (data_out !== e.d) $display("FAIL reset_first_data: got %h, required %h", data_out, e.d);
    else passes++;
    idle(3);
    do_clear();
  endtask

  task automatic test_arith();
    int acc0 [5] = '{1000, -20, 100000, -100000, 5};
    int bias0[5] = '{-24, 0, 0, 0, 3};
    int sh0  [5] = '{3, 2, 4, 4, 0};
`ifdef CONV_POST_RELU_EN
    int exp0 [5] = '{122, 0, 127, 0, 8};
`else
    int exp0 [5] = '{122, -5, 127, -128, 8};
`endif
    logic [N*AW-1:0] a;
    logic [DW-1:0] ev;
    beat_t e, o;
    for (int i = 0; i < 5; i++) begin
      bias_in = rand_bias_vec();
      bias_in[0 +: BW] = bias0[i][BW-1:0];
      shift_ctrl = sh0[i][SW-1:0];
      a = rand_acc_vec();
      a[0 +: AW] = acc0[i][AW-1:0];
      send(a);
      idle(5);
      checks++;
      if (obs_q.size() != 1) begin
        $display("FAIL arith_count case %0d: got %0d beats, required 1", i, obs_q.size());
      end else begin
        passes++;
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        ev = exp0[i][DW-1:0];
        checks++;
        if (o.d[DW-1:0] !== ev)
          $display("FAIL arith_ch0 case %0d: got %0d, required %0d", i, $signed(o.d[DW-1:0]), $signed(ev));
        else passes++;
        checks++;
        if (o.d !== e.d) $display("FAIL arith_vec case %0d: got %h, required %h", i, o.d, e.d);
        else passes++;
        checks++;
        if (o.le !== e.le || o.fe !== e.fe)
          $display("FAIL arith_tags case %0d: le/fe=%b%b, required %b%b", i, o.le, o.fe, e.le, e.fe);
        else passes++;
      end
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  // Back-to-back frames of random data; beat 13 must restart at col 0, row 0.
  task automatic test_back_to_back();
    beat_t e, o;
    for (int f = 0; f < 3; f++) begin
      line_len_ctrl   = 4;
      frame_rows_ctrl = 3;
      bias_in    = rand_bias_vec();
      shift_ctrl = SW'($urandom_range(0, 14));
      do_clear();
      for (int b = 0; b < 16; b++) send(rand_acc_vec());
      idle(5);
      checks++;
      if (obs_q.size() != exp_q.size())
        $display("FAIL b2b_count frame %0d: got %0d beats, required %0d", f, obs_q.size(), exp_q.size());
      else passes++;
      for (int b = 0; exp_q.size() > 0 && obs_q.size() > 0; b++) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        checks++;
        if (o.d !== e.d || o.le !== e.le || o.fe !== e.fe)
          $display("FAIL b2b beat %0d: data=%h le=%b fe=%b, required data=%h le=%b fe=%b",
                   b + 1, o.d, o.le, o.fe, e.d, e.le, e.fe);
        else passes++;
      end
    end
    do_clear();
  endtask

  // Gapped input keeps tags by beat count; cfg_rst drops in-flight beats.
  task automatic test_gaps_clear();
    beat_t e, o;
    line_len_ctrl   = 4;
    frame_rows_ctrl = 3;
    bias_in    = rand_bias_vec();
    shift_ctrl = SW'($urandom_range(0, 14));
    do_clear();
    for (int b = 0; b < 12; b++) begin
      send(rand_acc_vec());
      idle(1);
    end
    for (int b = 0; b < 5; b++) send(rand_acc_vec());
    idle(5);
    // Two more beats are in flight when cfg_rst arrives alongside a third.
    send(rand_acc_vec());
    send(rand_acc_vec());
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    acc_in   = rand_acc_vec();
    valid_in = 1'b1;
    cfg_rst  = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    cfg_rst  = 1'b0;
    beat_n   = 0;
    idle(5);
    for (int b = 0; b < 4; b++) send(rand_acc_vec());
    idle(5);
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL gaps_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int b = 0; exp_q.size() > 0 && obs_q.size() > 0; b++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.d !== e.d || o.le !== e.le || o.fe !== e.fe)
        $display("FAIL gaps beat %0d: data=%h le=%b fe=%b, required data=%h le=%b fe=%b",
                 b + 1, o.d, o.le, o.fe, e.d, e.le, e.fe);
      else passes++;
    end
    do_clear();
  endtask

  // Zero controls: every beat closes both a row and a frame.
  task automatic test_degenerate();
    beat_t e, o;
    line_len_ctrl   = 0;
    frame_rows_ctrl = 0;
    bias_in    = rand_bias_vec();
    shift_ctrl = SW'($urandom_range(0, 14));
    do_clear();
    for (int b = 0; b < 6; b++) begin
      send(rand_acc_vec());
      if (b[0]) idle(1);
    end
    idle(5);
    checks++;
    if (obs_q.size() != 6) $display("FAIL degen_count: got %0d beats, required 6", obs_q.size());
    else passes++;
    for (int b = 0; exp_q.size() > 0 && obs_q.size() > 0; b++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.d !== e.d || o.le !== 1'b1 || o.fe !== 1'b1)
        $display("FAIL degen beat %0d: data=%h le=%b fe=%b, required data=%h le=1 fe=1",
                 b + 1, o.d, o.le, o.fe, e.d);
      else passes++;
    end
    do_clear();
  endtask

  initial begin
    rstn            = 1'b0;
    acc_in          = '0;
    valid_in        = 1'b0;
    bias_in         = '0;
    shift_ctrl      = '0;
    line_len_ctrl   = 4;
    frame_rows_ctrl = 3;
    cfg_rst         = 1'b0;
    idle(3);
    test_reset();
    test_arith();
    test_back_to_back();
    test_gaps_clear();
    test_degenerate();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_post_process.md
# conv_post_process

Output-side counterpart of the convolution pre-processing stage. It consumes the per-output-channel accumulator vector produced by the MAC array for each output pixel, adds bias, requantizes (rounding arithmetic right shift, saturate to signed DATA_WIDTH), optionally applies ReLU, and packs the result into the feature-map stream written back to on-chip buffers. Position counters tag the last pixel of each output row and of each frame, so the writer needs no counters of its own.

## Interface
Parameters:
- CONV_OUT_NUM, 18, output channels processed in parallel
- DATA_WIDTH, 8, output activation width (signed)
- ACC_WIDTH, 24, accumulator width per channel (signed)
- BIAS_WIDTH, 16, bias width per channel (signed)
- SHIFT_WIDTH, 5, requantization shift control width
- ROW_BUFFER_DEPTH, 9, width of the line-length and row-count controls

Ports:
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- acc_in  in  CONV_OUT_NUM*ACC_WIDTH  accumulators; channel k at bits [k*ACC_WIDTH +: ACC_WIDTH]
- valid_in  in  1  acc_in valid this cycle
- bias_in  in  CONV_OUT_NUM*BIAS_WIDTH  per-channel bias, held static during a frame
- shift_ctrl  in  SHIFT_WIDTH  right-shift amount, static during a frame
- line_len_ctrl  in  ROW_BUFFER_DEPTH  output pixels per row
- frame_rows_ctrl  in  ROW_BUFFER_DEPTH  output rows per frame
- cfg_rst  in  1  synchronous clear of counters and pipeline valids
- data_out  out  CONV_OUT_NUM*DATA_WIDTH  requantized activations, same channel packing
- valid_out  out  1  data_out valid
- line_end  out  1  qualifies last pixel of a row (only with valid_out)
- frame_end  out  1  qualifies last pixel of a frame (only with valid_out)

## Operation
- No backpressure; every valid_in beat yields exactly one valid_out beat.
- Stage 1: s1 = sext(acc) + sext(bias), width ACC_WIDTH+1, no overflow possible.
- Stage 2: shift_ctrl=0 → s2 = s1; else s2 = (s1 + (1 << (shift_ctrl-1))) >>> shift_ctrl (round half toward +inf, arithmetic shift); computed at ACC_WIDTH+2 bits.
- Stage 3: saturate s2 to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; ReLU per Configuration.
- Counters advance on stage-3 valid: col 0..L-1, row 0..R-1, where L = max(line_len_ctrl,1), R = max(frame_rows_ctrl,1).
- line_end = valid_out && col==L-1; frame_end = line_end && row==R-1. After frame_end, col and row wrap to 0.
- cfg_rst: clears col, row and all stage valid bits that cycle; data registers untouched; valid_in in the same cycle is dropped. cfg_rst has priority over valid_in.
- Control changes mid-frame: counters compare against current values; if col already ≥ new L-1, next valid beat is treated as line end and col wraps.

## Timing
- Latency 3 cycles valid_in → valid_out; throughput one beat per cycle, back-to-back supported.
- line_end/frame_end registered, aligned with valid_out.
- Reset values: data_out 0, valid_out 0, line_end 0, frame_end 0, col 0, row 0, all pipeline valids 0.
- Reset asserted mid-frame: outputs drop immediately (async); in-flight beats lost.
- bias_in/shift_ctrl sampled at stage 1/stage 2 respectively; they must be stable for 3 cycles after a frame's last valid_in.

## Configuration
- CONV_POST_RELU_EN defined: stage 3 outputs max(sat,0); negative results become 0.
- Undefined: signed saturated value passes through; full signed range on data_out.

## Test plan
- Reset: rstn low mid-stream → valid_out, line_end, frame_end, data_out all 0 same cycle; first beat after release appears 3 cycles later.
- Arithmetic: acc=1000, bias=-24, shift=3 → (976+4)>>>3 = 122; acc=-20, bias=0, shift=2 → (-20+2)>>>2 = -5 (ReLU build: 0).
- Saturation: acc=100000, bias=0, shift=4 → 127; acc=-100000 → -128 (ReLU build: 0); shift=0, acc=5, bias=3 → 8.
- Framing: L=4, R=3, 12 contiguous beats → line_end on beats 4,8,12; frame_end only on beat 12; 13th beat has col=0,row=0.
- Gaps and clear: valid_in toggling every other cycle → same line_end positions by beat count; cfg_rst after 5 beats → next beat is col 0, row 0, and in-flight beats never produce valid_out.
- Degenerate: line_len_ctrl=0, frame_rows_ctrl=0 → every beat asserts line_end and frame_end.
